// File: rtl/apb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_arbiter
//  Description : Round-robin arbiter sharing one APB-like downstream request
//                port between an instruction-fetch master (M0) and a
//                load/store master (M1). One transaction in flight at a time,
//                with a release phase that waits for the downstream pready to
//                clear before the next request is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_arbiter #(
    parameter ADDR_WIDTH = 32,
    parameter DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    // master 0 (instruction fetch)
    input  logic [ADDR_WIDTH-1:0]     m0_paddr,
    input  logic [DATA_WIDTH-1:0]     m0_pdata,
    input  logic                      m0_pwrite,
    input  logic [DATA_WIDTH/8-1:0]   m0_pstb,
    input  logic                      m0_penable,
    output logic [DATA_WIDTH-1:0]     m0_prdata,
    output logic                      m0_pready,
    output logic                      m0_perr,
    // master 1 (load/store)
    input  logic [ADDR_WIDTH-1:0]     m1_paddr,
    input  logic [DATA_WIDTH-1:0]     m1_pdata,
    input  logic                      m1_pwrite,
    input  logic [DATA_WIDTH/8-1:0]   m1_pstb,
    input  logic                      m1_penable,
    output logic [DATA_WIDTH-1:0]     m1_prdata,
    output logic                      m1_pready,
    output logic                      m1_perr,
    // downstream port
    output logic [ADDR_WIDTH-1:0]     s_paddr,
    output logic [DATA_WIDTH-1:0]     s_pdata,
    output logic                      s_pwrite,
    output logic [DATA_WIDTH/8-1:0]   s_pstb,
    output logic                      s_penable,
    input  logic [DATA_WIDTH-1:0]     s_prdata,
    input  logic                      s_pready,
    input  logic                      s_perr
);

    localparam int         c_STB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_BUSY    = 2'd1;
    localparam logic [1:0] c_S_RELEASE = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;

    logic                   r_grant_id;
    logic                   r_rr_last;

    logic [ADDR_WIDTH-1:0]  r_s_paddr;
    logic [DATA_WIDTH-1:0]  r_s_pdata;
    logic                   r_s_pwrite;
    logic [c_STB_WIDTH-1:0] r_s_pstb;
    logic                   r_s_penable;

    logic [DATA_WIDTH-1:0]  r_cpl_prdata;
    logic                   r_cpl_perr;
    logic                   r_m0_pready;
    logic                   r_m1_pready;

    logic                   w_req_any;
    logic                   w_pick_m1;

    // M1 wins when it is the only requester, or on a tie when M0 was served last
    assign w_req_any = m0_penable | m1_penable;
    assign w_pick_m1 = m1_penable & (~m0_penable | ~r_rr_last);

    // State register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: issue, wait for completion, then wait for pready to clear
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:    if (w_req_any)  w_state_nxt = c_S_BUSY;
            c_S_BUSY:    if (s_pready)   w_state_nxt = c_S_RELEASE;
            c_S_RELEASE: if (!s_pready)  w_state_nxt = c_S_IDLE;
            default:                     w_state_nxt = c_S_IDLE;
        endcase
    end

    // Grant capture, downstream request fields and completion registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_grant_id   <= 1'b0;
            r_rr_last    <= 1'b1;
            r_s_paddr    <= '0;
            r_s_pdata    <= '0;
            r_s_pwrite   <= 1'b0;
            r_s_pstb     <= '0;
            r_s_penable  <= 1'b0;
            r_cpl_prdata <= '0;
            r_cpl_perr   <= 1'b0;
            r_m0_pready  <= 1'b0;
            r_m1_pready  <= 1'b0;
        end else begin
            // completion pulses last exactly one cycle
            r_m0_pready <= 1'b0;
            r_m1_pready <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_req_any) begin
                        r_grant_id  <= w_pick_m1;
                        r_rr_last   <= w_pick_m1;
                        r_s_penable <= 1'b1;
                        r_s_paddr   <= w_pick_m1 ? m1_paddr  : m0_paddr;
                        r_s_pdata   <= w_pick_m1 ? m1_pdata  : m0_pdata;
                        r_s_pwrite  <= w_pick_m1 ? m1_pwrite : m0_pwrite;
                        r_s_pstb    <= w_pick_m1 ? m1_pstb   : m0_pstb;
                    end
                end
                c_S_BUSY: begin
                    if (s_pready) begin
                        r_cpl_prdata <= s_prdata;
                        r_cpl_perr   <= s_perr;
                        r_m0_pready  <= ~r_grant_id;
                        r_m1_pready  <= r_grant_id;
                        r_s_penable  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_paddr   = r_s_paddr;
    assign s_pdata   = r_s_pdata;
    assign s_pwrite  = r_s_pwrite;
    assign s_pstb    = r_s_pstb;
    assign s_penable = r_s_penable;

    // both masters observe the shared completion registers, qualified by own pready
    assign m0_prdata = r_cpl_prdata;
    assign m1_prdata = r_cpl_prdata;
    assign m0_perr   = r_cpl_perr;
    assign m1_perr   = r_cpl_perr;
    assign m0_pready = r_m0_pready;
    assign m1_pready = r_m1_pready;

endmodule
`default_nettype wire

// File: doc/apb_arbiter.md
# apb_arbiter

Two-requester arbiter that shares the single APB-like request port of the AXI4-Lite translator between the instruction-fetch master (M0) and the load/store master (M1). It sequences one transaction at a time onto the downstream port, handles the downstream pready/penable release handshake, and returns each completion to the granted master as a one-cycle pulse. Arbitration is round-robin, so neither master can starve the other.

## Interface
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  asynchronous, active-low reset
- mN_paddr  in  ADDR_WIDTH  master N address (N = 0, 1)
- mN_pdata  in  DATA_WIDTH  master N write data
- mN_pwrite  in  1  master N direction, 1 = write
- mN_pstb  in  DATA_WIDTH/8  master N byte strobes
- mN_penable  in  1  master N request; held with stable fields until mN_pready
- mN_prdata  out  DATA_WIDTH  read data; valid in the mN_pready cycle
- mN_pready  out  1  one-cycle completion pulse to master N
- mN_perr  out  1  error flag; valid in the mN_pready cycle
- s_paddr, s_pdata, s_pwrite, s_pstb  out  as above  downstream request fields (registered)
- s_penable  out  1  downstream request
- s_prdata  in  DATA_WIDTH  downstream read data
- s_pready  in  1  downstream done; level, stays high until one cycle after s_penable falls
- s_perr  in  1  downstream error, valid with s_pready

## Operation
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - No mN_penable high: stay in IDLE.
  - Otherwise grant one master. Only one requesting: grant it. Both requesting: grant the one not granted last (rr_last; reset value 1, so M0 wins the first tie).
  - On grant: register the master's addr/data/write/stb into the s_* outputs, set grant_id, set s_penable=1, go to BUSY, update rr_last.
- BUSY:
  - s_* fields held constant.
  - On s_pready=1: latch s_prdata/s_perr into the shared completion registers, pulse m{grant_id}_pready, set s_penable=0, go to RELEASE.
- RELEASE:
  - Hold s_penable=0.
  - On s_pready=0: go to IDLE.
  - Guarantees the translator has cleared pready before the next request starts.
- mN_prdata/mN_perr: both masters see the same completion registers, which change only on completion. Each master qualifies them with its own pready.
- Master still holding mN_penable after its pready pulse: treated as a new request and arbitrated normally.
- Non-granted master dropping penable while waiting: request withdrawn, no effect.
- Granted master dropping penable during BUSY: transaction still completes downstream and the pready pulse is still issued. Not an error.
- Reset asserted (any state, including mid-BUSY):
  - Immediately: state=IDLE, s_penable=0, mN_pready=0, mN_perr=0, mN_prdata=0, s_paddr/s_pdata/s_pstb/s_pwrite=0, rr_last=1, grant_id=0.
  - The translator shares the reset, so no downstream cleanup is needed.

## Timing
- Request sampled at edge k in IDLE: s_penable and s_* valid after edge k (1-cycle grant latency).
- s_pready sampled high at edge j: mN_pready high for exactly the cycle after edge j; s_penable low after edge j.
- Translator drops s_pready after edge j+1. Arbiter sees it low at edge j+2 and enters IDLE. Earliest next s_penable rise is after edge j+3.
- Outputs are registered; there are no combinational paths from m* inputs to s* outputs.
- mN_pready is never high for two consecutive cycles, and never for both masters in the same cycle.

## Test plan
- Single read: M0 reads 0x1000; downstream returns 0xDEADBEEF, s_perr=0, 3 cycles after s_penable -> s_paddr=0x1000 one cycle after request, s_pwrite=0; m0_pready pulses once with m0_prdata=0xDEADBEEF, m0_perr=0; s_penable low the cycle m0_pready is high.
- Simultaneous requests: both raise penable in the same cycle after reset, M0 read 0x100 and M1 write 0x200/0x55AA55AA/strobe 0xF -> M0 granted first; M1 issued only after s_pready returns low, with s_pdata=0x55AA55AA, s_pstb=0xF; exactly one pready each.
- Fairness: both masters hold penable continuously for 6 transactions -> grant order M0, M1, M0, M1, M0, M1; each grant starts ≥3 cycles after the previous pready pulse.
- Error: downstream completes an M1 write with s_perr=1 -> m1_perr=1 during the m1_pready cycle; the next M0 read with s_perr=0 reports m0_perr=0.
- Reset mid-transaction: ARESETn low while in BUSY -> s_penable, mN_pready, mN_perr drop immediately; after release, a new M1 request is granted with no spurious pready.
- Withdrawal: M1 requests, then drops penable while M0 is in BUSY -> M1 never granted and m1_pready stays 0.
